expr_emitter: RTL and testbench
===============================

# expr_emitter

Serializes buffered arithmetic terms into an ASCII expression byte stream of the form digit ( op digit )*. Ops are '+' (0x2B) or '*' (0x2A); digits are '0'..'9' (0x30..0x39). It is the transmit-side counterpart of the expression-string checker. It drives that checker's 8-bit character input in test and demo setups, one character per accepted handshake.

## Interface
- DEPTH, 8, term FIFO capacity in entries (power of two, ≥2)
- clk  input  1  clock, all state updates on rising edge
- clr  input  1  reset, synchronous, active-high
- push  input  1  host offers a term this cycle
- push_digit  input  4  operand value, legal 0..9
- push_op  input  1  operator following this digit: 0 = '+', 1 = '*'; ignored when push_last=1
- push_last  input  1  this term ends the expression
- push_ready  output  1  FIFO not full; a push is accepted only when push=1 and push_ready=1
- out_data  output  8  ASCII character
- out_valid  output  1  out_data holds a character
- out_ready  input  1  sink accepts; transfer when out_valid=1 and out_ready=1
- done  output  1  one-cycle pulse after the final digit of an expression transfers
- err  output  1  sticky; set on a rejected push, cleared only by clr

## Operation
- FIFO entry: {digit[3:0], op, last}.
- Accepted push writes an entry at the clock edge.
- push with push_digit>9: entry not written, err<=1.
- push while push_ready=0: entry dropped, err<=1.
- FSM states:
  - IDLE: no expression in progress.
  - DIG: next character is a digit, popped from the FIFO.
  - OP: next character is the pending op.
- Output register loads when out_valid=0 or a transfer occurs this cycle ("slot free").
- IDLE/DIG + slot free + FIFO non-empty:
  - pop one entry; out_data<=0x30+digit; out_valid<=1.
  - If last=0: latch pending op, go to OP.
  - If last=1: go to IDLE and arm the final flag.
- IDLE/DIG + slot free + FIFO empty: out_valid<=0, stay in the current state (stall mid-expression is legal).
- OP + slot free: out_data<=(pending op ? 0x2A : 0x2B); out_valid<=1; go to DIG. No FIFO access.
- done<=1 for exactly one cycle, on the edge where the armed final digit transfers; the flag disarms then.
- Consecutive expressions stream back-to-back with no separator. The first digit of the next expression may load on the same edge the previous final digit transfers.
- Reset values: out_valid=0, out_data=8'h00, done=0, err=0, push_ready=1, FIFO empty, state IDLE, pending op=0, final flag=0.

## Timing
- out_data, out_valid and done are registered.
- push_ready is combinational from FIFO occupancy: 0 iff occupancy==DEPTH.
- No push-to-output bypass:
  - push accepted at edge E0 puts the entry in the FIFO;
  - digit is loaded at edge E1;
  - out_valid=1 in the cycle after E1 (first character appears 2 cycles after push sampled).
- Throughput: one character per cycle while out_ready=1 and the FIFO is non-empty whenever a digit is due.
- Backpressure: while out_valid=1 and out_ready=0, out_data is held stable and no pop occurs.
- Simultaneous push and pop:
  - Not full: both occur; occupancy unchanged.
  - Full: the push is rejected (full evaluated before the pop).
  - Empty: pop does not see the new entry until next cycle.
- Read/write pointers use log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - full = low bits equal, MSB differ.
  - empty = pointers equal.
- clr mid-expression: on the clr edge, all partial output and FIFO contents are discarded. The next expression begins cleanly with a digit; no orphan op is ever emitted.
- clr has priority over push and handshake in the same cycle.

## Test plan
- Reset, out_ready=1, push (7, x, last=1) in cycle 0 -> out_data=0x37 with out_valid=1 in cycle 2; done=1 in cycle 3 only; err=0.
- Push (3,+,0),(4,*,0),(5,x,1) in consecutive cycles, out_ready=1 -> out_data stream 0x33,0x2B,0x34,0x2A,0x35 on 5 consecutive cycles; one done pulse following the 0x35 transfer.
- Same stream, out_ready=0 for 3 cycles while 0x2B is valid -> 0x2B held for all 3 cycles; no pop; stream resumes unchanged; total 5 characters.
- out_ready=0, push 1+DEPTH+1 non-last terms:
  - push_ready falls when FIFO holds DEPTH entries;
  - the extra push is dropped and err=1 stays set;
  - the drained stream contains exactly the accepted digits in order.
- Push digit 12 -> no character emitted; err=1; a following valid push (9,x,1) emits 0x39 normally.
- Emit 0x33,0x2B, then assert clr for one cycle -> out_valid=0 and done=0 next cycle; push (8,x,1) -> stream is exactly 0x38; no stray '+' or '*'.

Source files
------------

// File: rtl/expr_emitter.sv
// rtl/expr_emitter.sv - term FIFO plus serializer emitting "digit (op digit)*" ASCII
// Terms are buffered as {digit, op, last}; the FSM alternates digit and op characters.
module expr_emitter #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       push,
   input  logic [3:0] push_digit,
   input  logic       push_op,
   input  logic       push_last,
   output logic       push_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       done,
   output logic       err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIG  = 2'd1,
      S_OP   = 2'd2
   } state_t;

   logic [5:0]  r_mem [DEPTH];
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   state_t      r_state;
   logic        r_pend_op;
   logic        r_final;
   logic [7:0]  r_out_data;
   logic        r_out_valid;
   logic        r_done;
   logic        r_err;

   logic        w_full;
   logic        w_empty;
   logic        w_accept;
   logic        w_slot;
   logic        w_xfer;
   logic [5:0]  w_head;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_empty  = (r_wptr == r_rptr);
   assign w_accept = push && !w_full && (push_digit <= 4'd9);
   assign w_slot   = !r_out_valid || out_ready;
   assign w_xfer   = r_out_valid && out_ready;
   assign w_head   = r_mem[r_rptr[AW-1:0]];

   assign push_ready = !w_full;
   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign done       = r_done;
   assign err        = r_err;

   always_ff @(posedge clk) begin
      if (!clr && w_accept) begin
         r_mem[r_wptr[AW-1:0]] <= {push_digit, push_op, push_last};
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_state     <= S_IDLE;
         r_pend_op   <= 1'b0;
         r_final     <= 1'b0;
         r_out_data  <= 8'h00;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (push && !w_accept) begin
            r_err <= 1'b1;
         end

         // The final flag tracks the character in the output register; a newly
         // loaded final digit below re-arms it on the same edge.
         r_done <= 1'b0;
         if (w_xfer && r_final) begin
            r_done  <= 1'b1;
            r_final <= 1'b0;
         end

         unique case (r_state)
            S_IDLE, S_DIG: begin
               if (w_slot) begin
                  if (!w_empty) begin
                     r_out_data  <= 8'h30 + {4'h0, w_head[5:2]};
                     r_out_valid <= 1'b1;
                     r_rptr      <= r_rptr + PTR_ONE;
                     if (w_head[0]) begin
                        r_state <= S_IDLE;
                        r_final <= 1'b1;
                     end else begin
                        r_pend_op <= w_head[1];
                        r_state   <= S_OP;
                     end
                  end else begin
                     r_out_valid <= 1'b0;
                  end
               end
            end
            S_OP: begin
               if (w_slot) begin
                  r_out_data  <= r_pend_op ? 8'h2A : 8'h2B;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DIG;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_expr_emitter.sv
// tb/tb_expr_emitter.sv - directed bench with expected-character scoreboard for expr_emitter
module tb_expr_emitter;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       clr;
   logic       push;
   logic [3:0] push_digit;
   logic       push_op;
   logic       push_last;
   logic       push_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       done;
   logic       err;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic mon_en = 1'b0;
   logic exp_done = 1'b0;
   logic [8:0] sb [$];
   int xfer_cyc [$];

   expr_emitter #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .clr        (clr),
      .push       (push),
      .push_digit (push_digit),
      .push_op    (push_op),
      .push_last  (push_last),
      .push_ready (push_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push = 1'b0;
   endtask

   // Drives one term for one edge; accepted terms queue their digit and op characters.
   task automatic do_push(input logic [3:0] d, input logic op, input logic last, input logic acc);
      push       = 1'b1;
      push_digit = d;
      push_op    = op;
      push_last  = last;
      if (acc) begin
         sb.push_back({last, 8'h30 + {4'h0, d}});
         if (!last) sb.push_back({1'b0, op ? 8'h2A : 8'h2B});
      end
      tick();
   endtask

   task automatic do_clr();
      clr = 1'b1;
      sb.delete();
      tick();
      clr = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
      repeat (3) tick();
      chk(tag, sb.size(), 0);
   endtask

   task automatic wait_char(input logic [7:0] c, input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (out_valid && out_data == c) found = 1'b1;
         else tick();
      end
      chk(tag, found, 1'b1);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         logic [8:0] e;
         cyc++;
         chk("done", done, exp_done);
         if (out_valid && out_ready && !clr) begin
            chk("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("out_data", out_data, e[7:0]);
               exp_done = e[8];
            end else begin
               exp_done = 1'b0;
            end
            xfer_cyc.push_back(cyc);
         end else begin
            exp_done = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clr = 1'b1; push = 1'b0; push_digit = 4'd0; push_op = 1'b0; push_last = 1'b0;
      out_ready = 1'b1;
      tick(); tick();
      clr = 1'b0;
      mon_en = 1'b1;

      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_push_ready", push_ready, 1'b1);

      // single-digit expression latency and done timing
      tick();
      do_push(4'd7, 1'b0, 1'b1, 1'b1);
      idle();
      @(negedge clk); chk("lat_c1_valid", out_valid, 1'b0);
      tick();
      @(negedge clk); chk("lat_c2_valid", out_valid, 1'b1); chk("lat_c2_data", out_data, 8'h37);
      tick();
      @(negedge clk); chk("lat_c3_done", done, 1'b1);
      tick();
      @(negedge clk); chk("lat_c4_done", done, 1'b0); chk("lat_err", err, 1'b0);
      wait_drain("single_drain");

      // throughput: five characters on consecutive cycles
      xfer_cyc.delete();
      do_push(4'd3, 1'b0, 1'b0, 1'b1);
      do_push(4'd4, 1'b1, 1'b0, 1'b1);
      do_push(4'd5, 1'b0, 1'b1, 1'b1);
      idle();
      wait_drain("tp_drain");
      chk("tp_count", xfer_cyc.size(), 5);
      chk("tp_span", (xfer_cyc.size() == 5) ? xfer_cyc[4] - xfer_cyc[0] : 32'hFFFF, 4);

      // backpressure holds '+' for three cycles
      xfer_cyc.delete();
      do_push(4'd3, 1'b0, 1'b0, 1'b1);
      do_push(4'd4, 1'b1, 1'b0, 1'b1);
      do_push(4'd5, 1'b0, 1'b1, 1'b1);
      idle();
      wait_char(8'h2B, "bp_found");
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         chk("bp_hold_data", out_data, 8'h2B);
         chk("bp_hold_valid", out_valid, 1'b1);
      end
      out_ready = 1'b1;
      wait_drain("bp_drain");
      chk("bp_count", xfer_cyc.size(), 5);

      // FIFO full: DEPTH+1 accepted with one in the output register, next one dropped
      do_clr();
      out_ready = 1'b0;
      for (int k = 1; k <= DEPTH + 1; k++) begin
         logic [3:0] kd;
         logic       ko;
         kd = 4'((k % 10));
         ko = 1'((k % 2));
         do_push(kd, ko, 1'b0, 1'b1);
      end
      chk("full_push_ready", push_ready, 1'b0);
      do_push(4'd5, 1'b0, 1'b0, 1'b0);
      idle();
      chk("full_err", err, 1'b1);
      chk("full_head_data", out_data, 8'h31);
      chk("full_head_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      repeat (6) tick();
      do_push(4'd0, 1'b0, 1'b1, 1'b1);
      idle();
      wait_drain("full_drain");
      chk("full_err_sticky", err, 1'b1);

      // illegal digit is rejected
      do_clr();
      do_push(4'd12, 1'b0, 1'b1, 1'b0);
      idle();
      repeat (3) tick();
      @(negedge clk);
      chk("bad_valid", out_valid, 1'b0);
      chk("bad_err", err, 1'b1);
      do_push(4'd9, 1'b0, 1'b1, 1'b1);
      idle();
      wait_drain("bad_drain");

      // clr mid-expression discards everything; no orphan op afterwards
      do_clr();
      do_push(4'd3, 1'b0, 1'b0, 1'b1);
      do_push(4'd4, 1'b1, 1'b0, 1'b1);
      idle();
      wait_char(8'h2B, "clr_found");
      do_clr();
      xfer_cyc.delete();
      @(negedge clk);
      chk("clr_valid", out_valid, 1'b0);
      chk("clr_done", done, 1'b0);
      chk("clr_err", err, 1'b0);
      tick();
      do_push(4'd8, 1'b0, 1'b1, 1'b1);
      idle();
      wait_drain("clr_drain");
      repeat (4) tick();
      chk("clr_count", xfer_cyc.size(), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
